// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: PC, prefetch queue and decode valid/ready handshake.
// Optional IFU_PERF_CNT_EN adds fetched/flushed event counters.
module instr_fetch_unit #(
  parameter int unsigned QDEPTH     = 2,
  parameter int unsigned IMEM_WORDS = 128,
  parameter logic [31:0] RESET_PC   = 32'd0
) (
  input  logic        clk,
  input  logic        rsta,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc,
  input  logic        redir_valid,
  input  logic [31:0] redir_target,
  output logic        fetch_fault
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_flushed
`endif
);

  localparam int unsigned PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QDEPTH);
  localparam logic [31:0]      MEM_LIMIT = 32'(IMEM_WORDS);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } q_entry_t;

  q_entry_t         q_mem_q [QDEPTH];
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      pc_q, pc_d;
  logic             fault_q, fault_d;

  logic pop_c;
  logic full_c;
  logic try_fetch_c;
  logic in_range_c;
  logic push_c;

  // Handshake and fetch qualification; redirect overrides both push and pop.
  always_comb begin
    pop_c       = (cnt_q != '0) && dec_ready && !redir_valid;
    full_c      = (cnt_q == FULL_CNT);
    try_fetch_c = !redir_valid && !fault_q && (!full_c || pop_c);
    in_range_c  = (pc_q < MEM_LIMIT);
    push_c      = try_fetch_c && in_range_c;
  end

  // Next-state for PC, pointers, occupancy and fault flag.
  always_comb begin
    pc_d    = pc_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    fault_d = fault_q;
    if (redir_valid) begin
      pc_d    = redir_target;
      rd_d    = '0;
      wr_d    = '0;
      cnt_d   = '0;
      fault_d = 1'b0;
    end else begin
      if (try_fetch_c && !in_range_c) begin
        fault_d = 1'b1;
      end
      if (push_c) begin
        pc_d = pc_q + 32'd1;
        wr_d = wr_q + PTR_W'(1);
      end
      if (pop_c) begin
        rd_d = rd_q + PTR_W'(1);
      end
      case ({push_c, pop_c})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rsta) begin
      pc_q    <= RESET_PC;
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  // Queue storage is cleared on reset so the head reads as zero until the first push.
  always_ff @(posedge clk) begin
    if (rsta) begin
      for (int i = 0; i < int'(QDEPTH); i++) begin
        q_mem_q[i] <= '0;
      end
    end else if (push_c) begin
      q_mem_q[wr_q] <= '{instr: imem_data, pc: pc_q};
    end
  end

  assign imem_addr   = pc_q;
  assign dec_valid   = (cnt_q != '0);
  assign dec_instr   = q_mem_q[rd_q].instr;
  assign dec_pc      = q_mem_q[rd_q].pc;
  assign fetch_fault = fault_q;

`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetched_q;
  logic [31:0] flushed_q;

  // Event counters wrap naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rsta) begin
      fetched_q <= '0;
      flushed_q <= '0;
    end else begin
      if (push_c) begin
        fetched_q <= fetched_q + 32'd1;
      end
      if (redir_valid) begin
        flushed_q <= flushed_q + 32'(cnt_q);
      end
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_flushed = flushed_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: queue-level reference model plus literal checkpoints.
module tb_instr_fetch_unit;

  localparam int unsigned QDEPTH = 2;
  localparam int unsigned WORDS  = 128;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  logic        clk = 1'b0;
  logic        rsta;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic        redir_valid;
  logic [31:0] redir_target;
  logic        fetch_fault;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_flushed;
`endif

  logic [31:0] imem [WORDS];

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Reference model state
  ent_t        mq[$];
  logic [31:0] m_pc;
  bit          m_fault;
  logic [31:0] m_fetched;
  logic [31:0] m_flushed;

  instr_fetch_unit #(.QDEPTH(QDEPTH), .IMEM_WORDS(WORDS), .RESET_PC(32'd0)) dut (
    .clk          (clk),
    .rsta         (rsta),
    .imem_addr    (imem_addr),
    .imem_data    (imem_data),
    .dec_valid    (dec_valid),
    .dec_ready    (dec_ready),
    .dec_instr    (dec_instr),
    .dec_pc       (dec_pc),
    .redir_valid  (redir_valid),
    .redir_target (redir_target),
    .fetch_fault  (fetch_fault)
`ifdef IFU_PERF_CNT_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_flushed (perf_flushed)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    logic [6:0] idx;
    idx = a[6:0];
    if (a < 32'(WORDS)) return imem[idx];
    return 32'hFFFF_FFFF;
  endfunction

  // Combinational instruction memory read port
  always_comb begin
    if (imem_addr < 32'(WORDS)) imem_data = imem[imem_addr[6:0]];
    else imem_data = 32'hFFFF_FFFF;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: advance one clock edge from the currently applied inputs.
  task automatic model_step();
    bit   pop;
    ent_t e;
    if (rsta) begin
      mq.delete();
      m_pc      = 32'd0;
      m_fault   = 1'b0;
      m_fetched = 32'd0;
      m_flushed = 32'd0;
    end else if (redir_valid) begin
      m_flushed = m_flushed + 32'(mq.size());
      mq.delete();
      m_pc    = redir_target;
      m_fault = 1'b0;
    end else begin
      pop = (mq.size() != 0) && dec_ready;
      if (pop) void'(mq.pop_front());
      if (!m_fault && (mq.size() < QDEPTH)) begin
        if (m_pc >= 32'(WORDS)) begin
          m_fault = 1'b1;
        end else begin
          e.instr = mem_rd(m_pc);
          e.pc    = m_pc;
          mq.push_back(e);
          m_pc      = m_pc + 32'd1;
          m_fetched = m_fetched + 32'd1;
        end
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Per-cycle comparison of DUT against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("imem_addr", imem_addr, m_pc);
      chk("dec_valid", 32'(dec_valid), 32'(mq.size() != 0));
      if (mq.size() != 0) begin
        chk("dec_pc", dec_pc, mq[0].pc);
        chk("dec_instr", dec_instr, mq[0].instr);
      end
      chk("fetch_fault", 32'(fetch_fault), 32'(m_fault));
`ifdef IFU_PERF_CNT_EN
      chk("perf_fetched", perf_fetched, m_fetched);
      chk("perf_flushed", perf_flushed, m_flushed);
`endif
    end
  end

  initial begin
    for (int i = 0; i < int'(WORDS); i++) imem[i] = 32'h1000_0000 + (i << 8) + i;
    imem[0]  = 32'h0635_0000;
    imem[26] = 32'h4790_0000;

    rsta = 1'b1; dec_ready = 1'b1; redir_valid = 1'b0; redir_target = 32'd0;
    cyc(); chk_en = 1'b1;
    cyc(); cyc();
    chk("rst_valid", 32'(dec_valid), 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    chk("rst_instr", dec_instr, 32'd0);
    chk("rst_pc", dec_pc, 32'd0);
    chk("rst_fault", 32'(fetch_fault), 32'd0);

    // Reset fetch, streaming one per cycle
    rsta = 1'b0;
    cyc();
    chk("first_valid", 32'(dec_valid), 32'd1);
    chk("first_pc", dec_pc, 32'd0);
    chk("first_instr", dec_instr, 32'h0635_0000);
    cyc(); chk("stream_pc1", dec_pc, 32'd1);
    cyc(); chk("stream_pc2", dec_pc, 32'd2);

    // Stall from reset: queue fills, PC holds at 2
    rsta = 1'b1; cyc();
    rsta = 1'b0; dec_ready = 1'b0;
    cyc(); cyc(); cyc(); cyc();
    chk("stall_addr", imem_addr, 32'd2);
    chk("stall_valid", 32'(dec_valid), 32'd1);
    chk("stall_pc", dec_pc, 32'd0);
    dec_ready = 1'b1;
    cyc(); chk("drain_pc1", dec_pc, 32'd1);
    cyc(); chk("drain_pc2", dec_pc, 32'd2);

    // Redirect to 26 while full with dec_ready high
    redir_valid = 1'b1; redir_target = 32'd26;
    cyc();
    chk("redir_valid_low", 32'(dec_valid), 32'd0);
    chk("redir_addr", imem_addr, 32'd26);
    redir_valid = 1'b0;
    cyc();
    chk("redir_pc", dec_pc, 32'd26);
    chk("redir_instr", dec_instr, 32'h4790_0000);

    // Fault at top of memory, then recovery
    redir_valid = 1'b1; redir_target = 32'd127;
    cyc();
    redir_valid = 1'b0;
    cyc();
    chk("last_pc", dec_pc, 32'd127);
    chk("last_valid", 32'(dec_valid), 32'd1);
    cyc();
    chk("fault_set", 32'(fetch_fault), 32'd1);
    chk("fault_drained", 32'(dec_valid), 32'd0);
    cyc(); cyc();
    chk("fault_hold", 32'(fetch_fault), 32'd1);
    chk("fault_addr", imem_addr, 32'd128);
    redir_valid = 1'b1; redir_target = 32'd0;
    cyc();
    chk("fault_clear", 32'(fetch_fault), 32'd0);
    redir_valid = 1'b0;
    cyc();
    chk("resume_pc", dec_pc, 32'd0);

    // Mid-operation reset with two entries queued
    dec_ready = 1'b0;
    cyc();
    rsta = 1'b1;
    cyc();
    chk("midrst_valid", 32'(dec_valid), 32'd0);
    chk("midrst_addr", imem_addr, 32'd0);
    chk("midrst_fault", 32'(fetch_fault), 32'd0);

    // Fetch 5, then redirect with 2 queued
    rsta = 1'b0; dec_ready = 1'b1;
    cyc(); cyc(); cyc(); cyc();
    dec_ready = 1'b0;
    cyc();
    chk("two_queued_pc", dec_pc, 32'd3);
    redir_valid = 1'b1; redir_target = 32'd10;
    cyc();
    redir_valid = 1'b0;
`ifdef IFU_PERF_CNT_EN
    chk("perf_fetched_5", perf_fetched, 32'd5);
    chk("perf_flushed_2", perf_flushed, 32'd2);
`endif

    // Mixed ready pattern with redirects, checked against the model every cycle
    for (int i = 0; i < 60; i++) begin
      dec_ready    = ((i % 5) != 1) && ((i % 7) != 3);
      redir_valid  = (i == 17) || (i == 40);
      redir_target = (i == 17) ? 32'd124 : 32'd3;
      cyc();
    end
    redir_valid = 1'b0;
    cyc(); cyc();

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
